// File: rtl/signed_seq_divider.sv
// rtl/signed_seq_divider.sv - signed 32/16 sequential restoring divider
// Magnitudes are divided one quotient bit per cycle; signs and exceptions are applied in FIX.
module signed_seq_divider (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] dividend,
  input  logic [15:0] divisor,
  output logic        busy,
  output logic        done,
  output logic [15:0] quotient,
  output logic [15:0] remainder,
  output logic        ovf,
  output logic        dbz
);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [16:0] dvs_q, dvs_d;
  logic [15:0] rem_q, rem_d;
  logic [15:0] quo_q, quo_d;
  logic        sdvd_q, sdvd_d;
  logic        sdvs_q, sdvs_d;
  logic        zero_q, zero_d;
  logic        early_q, early_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [15:0] quotient_q, quotient_d;
  logic [15:0] remainder_q, remainder_d;
  logic        ovf_q, ovf_d;
  logic        dbz_q, dbz_d;

  logic [31:0] dvd_mag;
  logic [16:0] dvs_mag;
  logic [16:0] trial;
  logic        fits;
  logic [15:0] diff;
  logic        neg;
  logic        range_ovf;
  logic [15:0] q_signed;
  logic [15:0] r_signed;

  // 32'h8000_0000 negates to itself, which read unsigned is exactly 2^31
  assign dvd_mag   = dividend[31] ? (~dividend + 32'd1) : dividend;
  assign dvs_mag   = divisor[15] ? (~{1'b1, divisor} + 17'd1) : {1'b0, divisor};
  assign trial     = {rem_q, quo_q[15]};
  assign fits      = (trial >= dvs_q);
  assign diff      = trial[15:0] - dvs_q[15:0];
  assign neg       = sdvd_q ^ sdvs_q;
  assign range_ovf = neg ? ({1'b0, quo_q} > 17'd32768) : ({1'b0, quo_q} > 17'd32767);
  assign q_signed  = neg ? (~quo_q + 16'd1) : quo_q;
  assign r_signed  = sdvd_q ? (~rem_q + 16'd1) : rem_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    dvs_d       = dvs_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    sdvd_d      = sdvd_q;
    sdvs_d      = sdvs_q;
    zero_d      = zero_q;
    early_d     = early_q;
    done_d      = 1'b0;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    ovf_d       = ovf_q;
    dbz_d       = dbz_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          sdvd_d  = dividend[31];
          sdvs_d  = divisor[15];
          dvs_d   = dvs_mag;
          rem_d   = dvd_mag[31:16];
          quo_d   = dvd_mag[15:0];
          zero_d  = (divisor == 16'd0);
          early_d = (divisor == 16'd0) || ({1'b0, dvd_mag[31:16]} >= dvs_mag);
          cnt_d   = 4'd0;
          state_d = early_d ? FIX : CALC;
        end
      end
      CALC: begin
        rem_d = fits ? diff : trial[15:0];
        quo_d = {quo_q[14:0], fits};
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd15) begin
          cnt_d   = 4'd0;
          state_d = FIX;
        end
      end
      FIX: begin
        // Early exceptions spend one extra FIX cycle so their latency is fixed at two cycles
        if (early_q && cnt_q == 4'd0) begin
          cnt_d = 4'd1;
        end else begin
          cnt_d   = 4'd0;
          done_d  = 1'b1;
          state_d = DONE;
          if (zero_q) begin
            quotient_d  = sdvd_q ? 16'h8000 : 16'h7FFF;
            remainder_d = 16'd0;
            ovf_d       = 1'b0;
            dbz_d       = 1'b1;
          end else if (early_q || range_ovf) begin
            quotient_d  = neg ? 16'h8000 : 16'h7FFF;
            remainder_d = 16'd0;
            ovf_d       = 1'b1;
            dbz_d       = 1'b0;
          end else begin
            quotient_d  = q_signed;
            remainder_d = r_signed;
            ovf_d       = 1'b0;
            dbz_d       = 1'b0;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      dvs_q       <= 17'd0;
      rem_q       <= 16'd0;
      quo_q       <= 16'd0;
      sdvd_q      <= 1'b0;
      sdvs_q      <= 1'b0;
      zero_q      <= 1'b0;
      early_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      quotient_q  <= 16'd0;
      remainder_q <= 16'd0;
      ovf_q       <= 1'b0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dvs_q       <= dvs_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      sdvd_q      <= sdvd_d;
      sdvs_q      <= sdvs_d;
      zero_q      <= zero_d;
      early_q     <= early_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      ovf_q       <= ovf_d;
      dbz_q       <= dbz_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign quotient  = quotient_q;
  assign remainder = remainder_q;
  assign ovf       = ovf_q;
  assign dbz       = dbz_q;

endmodule

// File: tb/tb_signed_seq_divider.sv
// tb/tb_signed_seq_divider.sv - scoreboard bench for signed_seq_divider
// Expected results come from plain signed integer division on the operands.
module tb_signed_seq_divider;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] dividend;
  logic [15:0] divisor;
  logic        busy;
  logic        done;
  logic [15:0] quotient;
  logic [15:0] remainder;
  logic        ovf;
  logic        dbz;

  signed_seq_divider dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .ovf       (ovf),
    .dbz       (dbz)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint      a;
    longint      b;
    logic [15:0] q;
    logic [15:0] r;
    logic        ovf;
    logic        dbz;
    longint      lat;
    longint      k;
  } exp_t;

  exp_t   sb[$];
  longint cyc = 0;
  int     n_checks = 0;
  int     n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  function automatic exp_t model(input logic [31:0] dvd, input logic [15:0] dvs);
    exp_t   e;
    longint qq;
    longint la;
    longint lb;
    e.a   = longint'($signed(dvd));
    e.b   = longint'($signed(dvs));
    e.ovf = 1'b0;
    e.dbz = 1'b0;
    la    = (e.a < 0) ? -e.a : e.a;
    lb    = (e.b < 0) ? -e.b : e.b;
    if (e.b == 0) begin
      e.dbz = 1'b1;
      e.q   = (e.a >= 0) ? 16'h7FFF : 16'h8000;
      e.r   = 16'd0;
      e.lat = 2;
    end else begin
      e.lat = ((la >> 16) >= lb) ? 2 : 17;
      qq    = e.a / e.b;
      if (qq > 32767 || qq < -32768) begin
        e.ovf = 1'b1;
        e.q   = ((e.a < 0) == (e.b < 0)) ? 16'h7FFF : 16'h8000;
        e.r   = 16'd0;
      end else begin
        e.q = 16'(qq);
        e.r = 16'(e.a % e.b);
      end
    end
    e.k = 0;
    return e;
  endfunction

  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("quotient", longint'(quotient), longint'(e.q));
        chk("remainder", longint'(remainder), longint'(e.r));
        chk("ovf", longint'(ovf), longint'(e.ovf));
        chk("dbz", longint'(dbz), longint'(e.dbz));
        chk("latency", cyc - e.k, e.lat);
        chk("busy_at_done", longint'(busy), 1);
        if (!e.ovf && !e.dbz)
          chk("identity", longint'($signed(quotient)) * e.b + longint'($signed(remainder)), e.a);
      end
    end
  end

  task automatic wait_drain();
    int t = 0;
    while (sb.size() != 0 && t < 40) begin
      @(negedge clk);
      #1;
      t++;
    end
    if (sb.size() != 0) begin
      chk("done_timeout", longint'(sb.size()), 0);
      sb.delete();
    end
  endtask

  task automatic issue(input logic [31:0] a, input logic [15:0] b, input bit expect_done);
    exp_t e;
    @(negedge clk);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    e        = model(a, b);
    e.k      = cyc + 1;
    if (expect_done) sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_op(input logic [31:0] a, input logic [15:0] b);
    issue(a, b, 1'b1);
    wait_drain();
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_busy"}, longint'(busy), 0);
    chk({tag, "_done"}, longint'(done), 0);
    chk({tag, "_quotient"}, longint'(quotient), 0);
    chk({tag, "_remainder"}, longint'(remainder), 0);
    chk({tag, "_ovf"}, longint'(ovf), 0);
    chk({tag, "_dbz"}, longint'(dbz), 0);
  endtask

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = 32'd0;
    divisor  = 16'd0;
    repeat (3) @(negedge clk);
    chk_zero_outputs("reset");
    rst_n = 1'b1;

    run_op(32'd100, 16'd7);
    repeat (3) @(negedge clk);
    chk("hold_quotient", longint'(quotient), 14);
    run_op(-32'sd100, 16'd7);
    run_op(32'd100, -16'sd7);
    run_op(-32'sd65536, 16'd2);
    run_op(32'd65536, 16'd2);
    run_op(32'h8000_0000, 16'hFFFF);
    run_op(32'd5, 16'd0);
    run_op(-32'sd5, 16'd0);
    run_op(32'h7FFF_FFFF, 16'h8000);
    run_op(32'h8000_0000, 16'h8000);
    run_op(-32'sd7, 16'd100);

    // A second start mid-operation must not disturb the first
    issue(32'd100, 16'd7, 1'b1);
    repeat (3) @(negedge clk);
    start    = 1'b1;
    dividend = 32'd1000;
    divisor  = 16'd3;
    @(negedge clk);
    start = 1'b0;
    wait_drain();

    // Reset mid-operation: no done, outputs cleared, next op behaves normally
    issue(32'd100, 16'd7, 1'b0);
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_zero_outputs("midreset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_op(32'd100, 16'd7);

    for (int i = 0; i < 3500; i++) begin
      logic [31:0] a;
      logic [15:0] b;
      longint      bm;
      longint      mag;
      int          sel;
      sel = $urandom_range(0, 7);
      b   = 16'($urandom);
      if (sel == 0) begin
        a = $urandom;
        if ($urandom_range(0, 3) == 0) b = 16'd0;
      end else begin
        if (sel == 1) b = 16'($urandom_range(1, 255));
        if (b == 16'd0) b = 16'd1;
        if ($urandom_range(0, 1) == 1 && b[15] == 1'b0) b = -b;
        bm  = longint'($signed(b));
        if (bm < 0) bm = -bm;
        mag = longint'($urandom) % (bm << 16);
        a   = ($urandom_range(0, 1) == 1) ? 32'(-mag) : 32'(mag);
      end
      run_op(a, b);
    end

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
